alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational 32-bit ALU (opcode/shamt driven, result plus isNotEqual/isLessThan/overflow) between two requesters, such as the fetch/branch unit and the execute unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one operation in flight at a time.
- ALU operands and results are registered so the ALU path is fully isolated between clock edges.

Parameters:
DATA_W, 32, operand/result width (ALU is fixed at 32; other values unsupported)
OP_W, 5, opcode and shift-amount width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_opA, req0_opB  in  32  requester 0 operands
req0_opcode, req0_shamt  in  5  requester 0 ALU opcode / shift amount
req1_valid, req1_ready, req1_opA, req1_opB, req1_opcode, req1_shamt  same as requester 0, for requester 1
resp0_valid, resp1_valid  out  1  response valid, per requester
resp0_ready, resp1_ready  in  1  requester can take response
resp_result  out  32  shared response data
resp_ne, resp_lt, resp_ovf  out  1  shared response flags
alu_opA, alu_opB  out  32  registered ALU operands
alu_opcode, alu_shamt  out  5  registered ALU controls
alu_result  in  32  ALU result
alu_ne, alu_lt, alu_ovf  in  1  ALU flags
perf_grant0, perf_grant1  out  16  grant counters (optional feature)

Behaviour:
- Reset: all outputs, including the counters, are 0; state=IDLE; last_grant=1, so requester 0 wins the first tie.
- States:
  - IDLE: if any req valid, grant the winner and assert its reqN_ready combinationally in this cycle. Latch opA/opB/opcode/shamt into the issue register and latch grant id. Go to EXEC.
  - EXEC: ALU is driven from the issue register. At the clock edge, capture alu_result/ne/lt/ovf into the response register and set respN_valid for the granted id. Go to HOLD.
  - HOLD: respN_valid held, and resp data held stable, until respN_ready.
    - On the handshake cycle, if any req is valid, accept the next winner in the same cycle and go to EXEC; otherwise go to IDLE.
    - respN_valid is cleared on the handshake unless a new response is produced.
- Arbitration: only one valid requester means it wins. Both valid means the id != last_grant wins. last_grant updates on every grant.
- reqN_ready is never asserted outside IDLE or a HOLD handshake cycle. Both reqN_ready signals are never high together.
- Latency: request accept at cycle T gives resp valid at T+2. Peak throughput is 1 op per 2 cycles.
- Response of the other id: respM_valid stays 0. respM_ready is ignored.
- Opcode is not checked; unsupported opcodes pass through and the ALU output is returned as-is.
- Request inputs may change after acceptance without effect. Deasserting reqN_valid before ready is legal, and that request is not granted.
- Reset mid-operation: the in-flight op is discarded, no response is issued, and last_grant returns to 1.
- alu_* outputs keep their last issued values while IDLE and do not toggle.

Optional Feature:
ALU_SHARE_PERF_EN
- Defined: perf_grant0/perf_grant1 increment on each grant to the respective requester. They are 16-bit, saturate at 0xFFFF and clear on reset.
- Undefined: the counters are not built and both ports are tied to 0.

Decomposition:
- Shared package alu_share_pkg:
  - opcode constants: ADD=5'b00000, SUB=5'b00001, AND=5'b00010, OR=5'b00011, SLL=5'b00100, SRA=5'b00101
  - state encoding: IDLE=2'd0, EXEC=2'd1, HOLD=2'd2
  - requester-id width
- One sub-module: rr_arbiter2 (combinational winner from two valids plus last_grant; outputs a one-hot grant).

Test Plan:
- Single op: req0 ADD 5+7 at T, resp0_ready=1 -> resp0_valid at T+2, result=12, ne=1, lt=1, ovf=0.
- Tie: both valid from reset, req0 SUB 3-3, req1 OR 0xF0|0x0F -> req0 granted first (result 0, ne=0). Then req1 result 0x000000FF; 4 cycles total.
- Fairness: both held valid for 6 ops -> grants alternate 0,1,0,1,0,1. With ALU_SHARE_PERF_EN, perf_grant0=perf_grant1=3.
- Backpressure: resp1_ready=0 for 5 cycles after resp1_valid with req0 pending -> resp data stable, req0_ready stays 0. It rises on the cycle resp1_ready=1.
- Overflow/shift: ADD 0x7FFFFFFF+1 -> ovf=1, result 0x80000000. SLL 1 by shamt 31 -> 0x80000000.
- Reset in EXEC: assert reset mid-op -> no resp valid, all outputs 0. The next tie grants req0.

Source files
------------

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared definitions for the two-requester ALU sharing block.
//   - ALU opcode constants (the opcode field is passed through unchecked)
//   - FSM state encoding
//   - requester-id type, issue/response register layouts
package alu_share_pkg;

   localparam int PKG_DATA_W = 32;
   localparam int PKG_OP_W   = 5;
   localparam int ID_W       = 1;

   localparam logic [PKG_OP_W-1:0] OP_ADD = 5'b00000;
   localparam logic [PKG_OP_W-1:0] OP_SUB = 5'b00001;
   localparam logic [PKG_OP_W-1:0] OP_AND = 5'b00010;
   localparam logic [PKG_OP_W-1:0] OP_OR  = 5'b00011;
   localparam logic [PKG_OP_W-1:0] OP_SLL = 5'b00100;
   localparam logic [PKG_OP_W-1:0] OP_SRA = 5'b00101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic [PKG_DATA_W-1:0] opA;
      logic [PKG_DATA_W-1:0] opB;
      logic [PKG_OP_W-1:0]   opcode;
      logic [PKG_OP_W-1:0]   shamt;
   } alu_req_t;

   typedef struct packed {
      logic [PKG_DATA_W-1:0] result;
      logic                  ne;
      logic                  lt;
      logic                  ovf;
   } alu_resp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick.
//   valid      - request valids {req1, req0}
//   last_grant - id granted most recently
//   gnt        - one-hot grant {req1, req0}; zero when nobody is valid
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (valid)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // contention: whoever did not win last time goes now
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two
// requesters with valid/ready request and response channels. One operation is
// in flight at a time; operands go out of an issue register and results come
// back into a response register, so the ALU sees a full cycle on its own.
//
// Ports:
//   clock, reset               rising-edge clock, async active-high reset
//   reqN_valid/ready           request handshake, N = 0,1
//   reqN_opA/opB/opcode/shamt  request operation
//   respN_valid/ready          response handshake, N = 0,1
//   resp_result/ne/lt/ovf      shared response payload
//   alu_opA/opB/opcode/shamt   registered ALU inputs
//   alu_result/ne/lt/ovf       ALU outputs
//   perf_grant0/1              saturating grant counters
//
// Build option: ALU_SHARE_PERF_EN builds the grant counters; without it the
// perf ports are tied to zero.
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_opA,
   input  logic [DATA_W-1:0] req0_opB,
   input  logic [OP_W-1:0]   req0_opcode,
   input  logic [OP_W-1:0]   req0_shamt,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_opA,
   input  logic [DATA_W-1:0] req1_opB,
   input  logic [OP_W-1:0]   req1_opcode,
   input  logic [OP_W-1:0]   req1_shamt,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp_result,
   output logic              resp_ne,
   output logic              resp_lt,
   output logic              resp_ovf,
   output logic [DATA_W-1:0] alu_opA,
   output logic [DATA_W-1:0] alu_opB,
   output logic [OP_W-1:0]   alu_opcode,
   output logic [OP_W-1:0]   alu_shamt,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_ne,
   input  logic              alu_lt,
   input  logic              alu_ovf,
   output logic [15:0]       perf_grant0,
   output logic [15:0]       perf_grant1
);

   state_t    state, state_nxt;
   logic      last_grant;
   req_id_t   gid;
   alu_req_t  issue;
   alu_resp_t resp;
   logic [1:0] resp_vld;
   logic [1:0] gnt;
   logic      resp_hs, accept, take;

   rr_arbiter2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   // Response handshake only counts against the id that owns the response;
   // the other requester's ready is don't-care.
   assign resp_hs = (state == HOLD) && (gid[0] ? resp1_ready : resp0_ready);
   // Acceptance windows: idle, or the cycle the held response drains.
   // Gated by reset so no ready leaks out while held in reset.
   assign accept  = !reset && ((state == IDLE) || resp_hs);
   assign take    = accept && (|gnt);

   assign req0_ready = accept & gnt[0];
   assign req1_ready = accept & gnt[1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = EXEC;
         EXEC:    state_nxt = HOLD;
         HOLD:    if (resp_hs) state_nxt = take ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         issue      <= '0;
         resp       <= '0;
         resp_vld   <= 2'b00;
         gid        <= '0;
         last_grant <= 1'b1;
      end else begin
         if (take) begin
            issue      <= gnt[1] ? alu_req_t'{req1_opA, req1_opB, req1_opcode, req1_shamt}
                                 : alu_req_t'{req0_opA, req0_opB, req0_opcode, req0_shamt};
            gid        <= req_id_t'(gnt[1]);
            last_grant <= gnt[1];
         end
         if (state == EXEC) begin
            resp     <= alu_resp_t'{alu_result, alu_ne, alu_lt, alu_ovf};
            resp_vld <= gid[0] ? 2'b10 : 2'b01;
         end else if (resp_hs) begin
            // payload is left in place; only the valid drops
            resp_vld <= 2'b00;
         end
      end
   end

   assign alu_opA     = issue.opA;
   assign alu_opB     = issue.opB;
   assign alu_opcode  = issue.opcode;
   assign alu_shamt   = issue.shamt;
   assign resp_result = resp.result;
   assign resp_ne     = resp.ne;
   assign resp_lt     = resp.lt;
   assign resp_ovf    = resp.ovf;
   assign resp0_valid = resp_vld[0];
   assign resp1_valid = resp_vld[1];

`ifdef ALU_SHARE_PERF_EN
   logic [15:0] cnt0, cnt1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (req0_ready && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
         if (req1_ready && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'd1;
      end
   end

   assign perf_grant0 = cnt0;
   assign perf_grant1 = cnt1;
`else
   assign perf_grant0 = '0;
   assign perf_grant1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for alu_share_arbiter with a
// behavioural ALU and an in-order response scoreboard.
// Honours ALU_SHARE_PERF_EN for the grant-counter expectations.
module tb_alu_share_arbiter;
   import alu_share_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_opA, req0_opB, req1_opA, req1_opB;
   logic [4:0]  req0_opcode, req0_shamt, req1_opcode, req1_shamt;
   logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [31:0] resp_result;
   logic        resp_ne, resp_lt, resp_ovf;
   logic [31:0] alu_opA, alu_opB, alu_result;
   logic [4:0]  alu_opcode, alu_shamt;
   logic        alu_ne, alu_lt, alu_ovf;
   logic [15:0] perf_grant0, perf_grant1;

   always #5 clock = ~clock;

   alu_share_arbiter dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_opA(req0_opA), .req0_opB(req0_opB),
      .req0_opcode(req0_opcode), .req0_shamt(req0_shamt),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_opA(req1_opA), .req1_opB(req1_opB),
      .req1_opcode(req1_opcode), .req1_shamt(req1_shamt),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_result(resp_result), .resp_ne(resp_ne), .resp_lt(resp_lt), .resp_ovf(resp_ovf),
      .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf),
      .perf_grant0(perf_grant0), .perf_grant1(perf_grant1)
   );

   // behavioural ALU; unknown opcodes return ~opA so pass-through is visible
   function automatic alu_resp_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op, input logic [4:0] sh);
      alu_resp_t r;
      r.result = ~a;
      r.ovf    = 1'b0;
      case (op)
         OP_ADD: begin r.result = a + b; r.ovf = (a[31] == b[31]) && (r.result[31] != a[31]); end
         OP_SUB: begin r.result = a - b; r.ovf = (a[31] != b[31]) && (r.result[31] != a[31]); end
         OP_AND: r.result = a & b;
         OP_OR:  r.result = a | b;
         OP_SLL: r.result = a << sh;
         OP_SRA: r.result = 32'($signed(a) >>> sh);
         default: ;
      endcase
      r.ne = (a != b);
      r.lt = ($signed(a) < $signed(b));
      return r;
   endfunction

   alu_resp_t alu_m;
   always_comb alu_m = ref_alu(alu_opA, alu_opB, alu_opcode, alu_shamt);
   assign alu_result = alu_m.result;
   assign alu_ne     = alu_m.ne;
   assign alu_lt     = alu_m.lt;
   assign alu_ovf    = alu_m.ovf;

   typedef struct {
      logic      id;
      alu_resp_t r;
      int        acc;
      bit        seen;
   } exp_t;

   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // sample point: negedge; checks outstanding response, tracks accepts
   task automatic sample();
      @(negedge clock);
      cyc++;
      chk("ready_excl", 32'(req0_ready & req1_ready), 32'd0);
      if (resp0_valid || resp1_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
         end else begin
            chk("resp_id",     32'({resp1_valid, resp0_valid}), sb[0].id ? 32'd2 : 32'd1);
            chk("resp_result", resp_result, sb[0].r.result);
            chk("resp_ne",     32'(resp_ne),  32'(sb[0].r.ne));
            chk("resp_lt",     32'(resp_lt),  32'(sb[0].r.lt));
            chk("resp_ovf",    32'(resp_ovf), 32'(sb[0].r.ovf));
            if (!sb[0].seen) begin
               chk("latency", 32'(cyc), 32'(sb[0].acc + 2));
               sb[0].seen = 1'b1;
            end
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready))
               void'(sb.pop_front());
         end
      end
      if (req0_valid && req0_ready)
         sb.push_back('{1'b0, ref_alu(req0_opA, req0_opB, req0_opcode, req0_shamt), cyc, 1'b0});
      if (req1_valid && req1_ready)
         sb.push_back('{1'b1, ref_alu(req1_opA, req1_opB, req1_opcode, req1_shamt), cyc, 1'b0});
   endtask

   task automatic adv();
      @(posedge clock);
      #1;
   endtask

   task automatic step();
      sample();
      adv();
   endtask

   task automatic set_req(input logic id, input logic v, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      if (id) begin
         req1_valid = v; req1_opcode = op; req1_opA = a; req1_opB = b; req1_shamt = sh;
      end else begin
         req0_valid = v; req0_opcode = op; req0_opA = a; req0_opB = b; req0_shamt = sh;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rdy"},  32'({req1_ready, req0_ready}), 32'd0);
      chk({tag, "_rvld"}, 32'({resp1_valid, resp0_valid}), 32'd0);
      chk({tag, "_res"},  resp_result, 32'd0);
      chk({tag, "_flg"},  32'({resp_ne, resp_lt, resp_ovf}), 32'd0);
      chk({tag, "_aluA"}, alu_opA, 32'd0);
      chk({tag, "_aluB"}, alu_opB, 32'd0);
      chk({tag, "_aluc"}, 32'({alu_opcode, alu_shamt}), 32'd0);
      chk({tag, "_perf"}, {perf_grant1, perf_grant0}, 32'd0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      set_req(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      set_req(1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      sb.delete();
      adv();
      sample();
      check_zero("reset");
      adv();
      reset = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && sb.size() > 0; t++) step();
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_op(input logic id, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, output alu_resp_t r);
      bit got;
      got = 1'b0;
      r   = '0;
      set_req(id, 1'b1, op, a, b, sh);
      for (int t = 0; t < 10 && !got; t++) begin
         sample();
         got = id ? req1_ready : req0_ready;
         adv();
      end
      chk("op_accept", 32'(got), 32'd1);
      set_req(id, 1'b0, op, a, b, sh);
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
         sample();
         if (id ? resp1_valid : resp0_valid) begin
            got = 1'b1;
            r   = '{resp_result, resp_ne, resp_lt, resp_ovf};
         end
         adv();
      end
      chk("op_resp", 32'(got), 32'd1);
   endtask

   initial begin
      alu_resp_t r;
      int        g;
      reset = 1'b1;
      apply_reset();

      // single op: ADD 5+7, accept at T, response at T+2
      set_req(1'b0, 1'b1, OP_ADD, 32'd5, 32'd7, 5'd0);
      sample();
      chk("single_rdy", 32'(req0_ready), 32'd1);
      adv();
      set_req(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      sample();
      chk("single_exec_vld", 32'(resp0_valid), 32'd0);
      chk("single_aluA", alu_opA, 32'd5);
      chk("single_aluB", alu_opB, 32'd7);
      adv();
      sample();
      chk("single_vld", 32'(resp0_valid), 32'd1);
      chk("single_res", resp_result, 32'd12);
      chk("single_flags", 32'({resp_ne, resp_lt, resp_ovf}), 32'b110);
      adv();
      sample();
      chk("single_clear", 32'(resp0_valid), 32'd0);
      adv();

      // tie from reset: req0 first, req1 rides the handshake cycle
      apply_reset();
      set_req(1'b0, 1'b1, OP_SUB, 32'd3, 32'd3, 5'd0);
      set_req(1'b1, 1'b1, OP_OR, 32'hF0, 32'h0F, 5'd0);
      sample();
      chk("tie_rdy", 32'({req1_ready, req0_ready}), 32'b01);
      adv();
      set_req(1'b0, 1'b0, OP_SUB, 32'd0, 32'd0, 5'd0);
      step();
      sample();
      chk("tie_res0", resp_result, 32'd0);
      chk("tie_ne0", 32'(resp_ne), 32'd0);
      chk("tie_rdy1", 32'(req1_ready), 32'd1);
      adv();
      set_req(1'b1, 1'b0, OP_OR, 32'd0, 32'd0, 5'd0);
      step();
      sample();
      chk("tie_vld1", 32'(resp1_valid), 32'd1);
      chk("tie_res1", resp_result, 32'h0000_00FF);
      adv();

      // fairness: both held valid, grants must alternate starting with req0
      apply_reset();
      g = 0;
      set_req(1'b0, 1'b1, OP_ADD, $urandom, $urandom, 5'd0);
      set_req(1'b1, 1'b1, OP_SUB, $urandom, $urandom, 5'd0);
      for (int t = 0; t < 30 && g < 6; t++) begin
         sample();
         if (req0_ready || req1_ready) begin
            chk("fair_grant", 32'(req1_ready), 32'(g % 2));
            g++;
         end
         adv();
         req0_opA = $urandom; req0_opB = $urandom;
         req1_opA = $urandom; req1_opB = $urandom;
      end
      chk("fair_count", 32'(g), 32'd6);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();
`ifdef ALU_SHARE_PERF_EN
      chk("perf_grants", {perf_grant1, perf_grant0}, {16'd3, 16'd3});
`else
      chk("perf_grants", {perf_grant1, perf_grant0}, 32'd0);
`endif

      // backpressure on resp1 with req0 pending
      apply_reset();
      resp1_ready = 1'b0;
      set_req(1'b1, 1'b1, OP_OR, 32'h1234_0000, 32'h0000_00FF, 5'd0);
      step();
      set_req(1'b1, 1'b0, OP_OR, 32'd0, 32'd0, 5'd0);
      set_req(1'b0, 1'b1, OP_ADD, 32'd1, 32'd2, 5'd0);
      sample();
      chk("bp_exec_rdy", 32'(req0_ready), 32'd0);
      adv();
      for (int t = 0; t < 5; t++) begin
         sample();
         chk("bp_vld", 32'(resp1_valid), 32'd1);
         chk("bp_rdy0", 32'(req0_ready), 32'd0);
         chk("bp_data", resp_result, 32'h1234_00FF);
         adv();
      end
      resp1_ready = 1'b1;
      sample();
      chk("bp_release", 32'(req0_ready), 32'd1);
      adv();
      set_req(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      drain();

      // overflow, shifts, pass-through opcode
      do_op(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, r);
      chk("ovf_res", r.result, 32'h8000_0000);
      chk("ovf_flag", 32'(r.ovf), 32'd1);
      do_op(1'b0, OP_SLL, 32'd1, 32'd0, 5'd31, r);
      chk("sll_res", r.result, 32'h8000_0000);
      do_op(1'b0, 5'b11111, 32'h0F0F_0000, 32'd0, 5'd0, r);
      chk("passthru_res", r.result, 32'hF0F0_FFFF);
      do_op(1'b1, OP_SRA, 32'h8000_0000, 32'd0, 5'd4, r);
      chk("sra_res", r.result, 32'hF800_0000);
      step();
      sample();
      chk("idle_aluA", alu_opA, 32'h8000_0000);
      chk("idle_aluc", 32'({alu_opcode, alu_shamt}), 32'({OP_SRA, 5'd4}));
      adv();

      // reset while in EXEC: op is dropped, arbiter pointer returns to req1
      set_req(1'b1, 1'b1, OP_ADD, 32'd10, 32'd20, 5'd0);
      step();
      set_req(1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      reset = 1'b1;
      sb.delete();
      sample();
      check_zero("rst_exec");
      adv();
      reset = 1'b0;
      for (int t = 0; t < 3; t++) begin
         sample();
         chk("rst_novld", 32'({resp1_valid, resp0_valid}), 32'd0);
         adv();
      end
      set_req(1'b0, 1'b1, OP_AND, 32'hFF00, 32'h0FF0, 5'd0);
      set_req(1'b1, 1'b1, OP_AND, 32'h1, 32'h1, 5'd0);
      sample();
      chk("rst_tie", 32'({req1_ready, req0_ready}), 32'b01);
      adv();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
